// File: rtl/config_chain_pkg.sv
// Shared types and constants for the serial config chain and its CRC-8 checker.
// CONFIG_CRC_EN selects whether the chain carries eight appended check bits.
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FULL,
        OVERRUN
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int         CRC_W     = 8;

`ifdef CONFIG_CRC_EN
    localparam int CRC_WIDTH = CRC_W;
`else
    localparam int CRC_WIDTH = 0;
`endif

endpackage

// File: rtl/config_crc8_serial.sv
// Serial CRC-8 (MSB-first) residue over shifted chain bits; built only with CONFIG_CRC_EN.
// Residue updates one cycle after each valid bit; clear restarts from init, same-cycle bit included.
`ifdef CONFIG_CRC_EN
module config_crc8_serial
    import config_chain_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [CRC_W-1:0] residue
);

    logic [CRC_W-1:0] r_residue;
    logic [CRC_W-1:0] w_base;
    logic [CRC_W-1:0] w_next;
    logic             w_fb;

    // A bit arriving with clear is the first bit of the next frame.
    assign w_base = clear ? CRC8_INIT : r_residue;
    assign w_fb   = w_base[CRC_W-1] ^ bit_in;

    always_comb begin
        w_next = w_base;
        if (bit_valid) begin
            w_next = {w_base[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC8_POLY : '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_residue <= CRC8_INIT;
        end else begin
            r_residue <= w_next;
        end
    end

    assign residue = r_residue;

endmodule
`endif

// File: rtl/config_chain_ctrl.sv
// Serial config chain with bit counting, checked commit into a shadow word and sticky error.
// Commit-to-config_data latency 1 cycle; no backpressure. CONFIG_CRC_EN appends a CRC-8 check.
module config_chain_ctrl
    import config_chain_pkg::*;
#(
    parameter  int CONFIG_WIDTH = 29,
    localparam int CHAIN_W      = CONFIG_WIDTH + CRC_WIDTH,
    localparam int CNT_W        = $clog2(CHAIN_W + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    config_in,
    input  logic                    config_enable,
    input  logic                    config_commit,
    input  logic                    error_clear,
    output logic                    config_out,
    output logic [CONFIG_WIDTH-1:0] config_data,
    output logic                    config_valid,
    output logic [CNT_W-1:0]        bit_count,
    output logic                    error
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CHAIN_W-1:0]      r_chain;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [CONFIG_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_err;
    logic                    w_crc_ok;
    logic                    w_commit_ok;
    logic                    w_commit_rej;

`ifdef CONFIG_CRC_EN
    logic [CRC_W-1:0] w_residue;

    config_crc8_serial u_crc (
        .clock     (clock),
        .reset     (reset),
        .clear     (config_commit),
        .bit_valid (config_enable),
        .bit_in    (config_in),
        .residue   (w_residue)
    );

    assign w_crc_ok = (w_residue == '0);
`else
    assign w_crc_ok = 1'b1;
`endif

    assign w_commit_ok  = config_commit && (r_state == FULL) && w_crc_ok;
    assign w_commit_rej = config_commit && !w_commit_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (config_commit) begin
            // A bit shifted alongside a commit starts the next frame.
            if (config_enable) begin
                w_state_nxt = LOADING;
                w_count_nxt = CNT_W'(1);
            end else begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        end else if (config_enable) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = LOADING;
                    w_count_nxt = CNT_W'(1);
                end
                LOADING: begin
                    w_count_nxt = r_count + CNT_W'(1);
                    if (r_count == CNT_W'(CHAIN_W - 1)) begin
                        w_state_nxt = FULL;
                    end
                end
                FULL:    w_state_nxt = OVERRUN;
                OVERRUN: w_state_nxt = OVERRUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_chain <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (config_enable) begin
                r_chain <= {r_chain[CHAIN_W-2:0], config_in};
            end
            if (w_commit_ok) begin
                r_data  <= r_chain[CHAIN_W-1 -: CONFIG_WIDTH];
                r_valid <= 1'b1;
            end
            if (w_commit_rej) begin
                r_err <= 1'b1;
            end else if (error_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign config_out   = r_chain[CHAIN_W-1];
    assign config_data  = r_data;
    assign config_valid = r_valid;
    assign bit_count    = r_count;
    assign error        = r_err;

endmodule

// File: tb/tb_config_chain_ctrl.sv
// Scoreboard bench for config_chain_ctrl: stimulus queues expected state, a negedge monitor compares.
// Builds with or without CONFIG_CRC_EN; the CRC-specific vectors run only when it is defined.
module tb_config_chain_ctrl;

`ifdef CONFIG_CRC_EN
    localparam int CRCW = 8;
`else
    localparam int CRCW = 0;
`endif
    localparam int CW      = 29;
    localparam int CHAIN_W = CW + CRCW;
    localparam int CNT_W   = $clog2(CHAIN_W + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             config_in = 1'b0;
    logic             config_enable = 1'b0;
    logic             config_commit = 1'b0;
    logic             error_clear = 1'b0;
    logic             config_out;
    logic [CW-1:0]    config_data;
    logic             config_valid;
    logic [CNT_W-1:0] bit_count;
    logic             error;

    config_chain_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .config_in     (config_in),
        .config_enable (config_enable),
        .config_commit (config_commit),
        .error_clear   (error_clear),
        .config_out    (config_out),
        .config_data   (config_data),
        .config_valid  (config_valid),
        .bit_count     (bit_count),
        .error         (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [CW-1:0] data;
        logic        valid;
        logic        err;
        int          cnt;
        int          cout;   // -1: do not check config_out
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic chk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (chk) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: sample with empty scoreboard");
            end else begin
                e = q.pop_front();
                cmp(e.name, "config_data", int'(config_data), int'(e.data));
                cmp(e.name, "config_valid", int'(config_valid), int'(e.valid));
                cmp(e.name, "error", int'(error), int'(e.err));
                cmp(e.name, "bit_count", int'(bit_count), e.cnt);
                if (e.cout >= 0) cmp(e.name, "config_out", int'(config_out), e.cout);
            end
        end
    end

    function automatic logic [CHAIN_W-1:0] mk_frame(input logic [CW-1:0] d);
`ifdef CONFIG_CRC_EN
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = CW - 1; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return {d, r};
`else
        return d;
`endif
    endfunction

    task automatic drive(input logic en, input logic b, input logic cm, input logic ec);
        config_enable = en;
        config_in     = b;
        config_commit = cm;
        error_clear   = ec;
        @(posedge clock);
        #1;
        config_enable = 1'b0;
        config_in     = 1'b0;
        config_commit = 1'b0;
        error_clear   = 1'b0;
    endtask

    task automatic shift_bits(input logic [CHAIN_W-1:0] f, input int first, input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = first + i;
            drive(1'b1, (idx < CHAIN_W) ? f[CHAIN_W-1-idx] : 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic expect_now(input string nm, input logic [CW-1:0] d, input logic v,
                              input logic er, input int c, input int co);
        q.push_back('{nm, d, v, er, c, co});
        chk = 1'b1;
        @(negedge clock);
        #1;
        chk = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CHAIN_W-1:0] f1, f3, f5, f6, fz;

        f1 = mk_frame(29'h1555_5555);
        f3 = mk_frame(29'h1000_0000);
        f5 = mk_frame(29'h0ABC_DEF1);
        f6 = mk_frame(29'h1234_5678);

        @(posedge clock);
        #1;
        expect_now("reset", '0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;

        // Short chain: rejected commit, then set-beats-clear, then clear.
        shift_bits(mk_frame(29'h0F0F_0F0F), 0, CHAIN_W - 1);
        expect_now("t2_count", '0, 1'b0, 1'b0, CHAIN_W - 1, -1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t2_reject", '0, 1'b0, 1'b1, 0, -1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        expect_now("set_wins", '0, 1'b0, 1'b1, 0, -1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_now("t2_clear", '0, 1'b0, 1'b0, 0, -1);

        // Full chain, clean commit.
        shift_bits(f1, 0, CHAIN_W);
        expect_now("t1_full", '0, 1'b0, 1'b0, CHAIN_W, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t1_commit", 29'h1555_5555, 1'b1, 1'b0, 0, -1);

        // Overrun: first bit reaches config_out at full, count saturates, commit rejected.
        shift_bits(f3, 0, CHAIN_W);
        expect_now("t3_full", 29'h1555_5555, 1'b1, 1'b0, CHAIN_W, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("t3_overrun", 29'h1555_5555, 1'b1, 1'b0, CHAIN_W, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t3_reject", 29'h1555_5555, 1'b1, 1'b1, 0, -1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_now("t3_clear", 29'h1555_5555, 1'b1, 1'b0, 0, -1);

        // Commit with a same-cycle shift: that bit opens the next frame.
        shift_bits(f5, 0, CHAIN_W);
        drive(1'b1, f6[CHAIN_W-1], 1'b1, 1'b0);
        expect_now("t5_commit", 29'h0ABC_DEF1, 1'b1, 1'b0, 1, -1);
        shift_bits(f6, 1, CHAIN_W - 1);
        expect_now("t5_full", 29'h0ABC_DEF1, 1'b1, 1'b0, CHAIN_W, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t5_next", 29'h1234_5678, 1'b1, 1'b0, 0, -1);

        // Asynchronous reset mid-cycle during a partial load.
        shift_bits(f1, 0, 15);
        expect_now("t4_partial", 29'h1234_5678, 1'b1, 1'b0, 15, -1);
        #2;
        reset = 1'b1;
        expect_now("t4_reset", '0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;

`ifdef CONFIG_CRC_EN
        fz = '0;
        shift_bits(fz, 0, CHAIN_W);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t6_zero_ok", '0, 1'b1, 1'b0, 0, -1);
        fz[CRCW + 5] = 1'b1;
        shift_bits(fz, 0, CHAIN_W);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("t6_bad_crc", '0, 1'b1, 1'b1, 0, -1);
`else
        fz = '0;
`endif

        repeat (2) @(posedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
